// File: rtl/regbank_param.sv
// Parametrised control/status register bank with per-register access types,
// key-unlock write protection, a registered read path and a W1C interrupt.
module regbank_param #(
  parameter int                          DATA_W        = 32,
  parameter int                          NUM_REGS      = 8,
  parameter int                          ADDR_W        = 8,
  parameter logic [3*NUM_REGS-1:0]       ACC_TYPE      = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RST_VAL       = '0,
  parameter logic [NUM_REGS-1:0]         LOCK_MASK     = '0,
  parameter logic [31:0]                 LOCK_KEY      = 32'hA5A5_5A5A,
  parameter int                          UNLOCK_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         chip_select,
  input  logic                         write_en,
  input  logic                         read_en,
  input  logic [DATA_W-1:0]            write_data,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic [DATA_W-1:0]            read_data,
  output logic                         data_valid,
  output logic                         slv_err,
  input  logic [NUM_REGS-1:0]          hw_wen,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         unlocked,
  output logic                         irq
);

  localparam int                 STRB_W    = DATA_W / 8;
  localparam int                 CNT_W     = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [ADDR_W-1:0]  LOCK_ADDR = ADDR_W'(4 * NUM_REGS);
  localparam logic [DATA_W-1:0]  KEY       = DATA_W'(LOCK_KEY);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(UNLOCK_CYCLES);

  localparam logic [2:0] ACC_RW    = 3'd0;
  localparam logic [2:0] ACC_RO    = 3'd1;
  localparam logic [2:0] ACC_WO    = 3'd2;
  localparam logic [2:0] ACC_W1C   = 3'd3;
  localparam logic [2:0] ACC_W1S   = 3'd4;
  localparam logic [2:0] ACC_PULSE = 3'd5;

  typedef enum logic {LOCKED, OPEN} lock_state_t;

  logic                 wr, rd;
  logic [ADDR_W-1:0]    waddr;
  logic                 in_range, is_lock;
  logic [DATA_W-1:0]    bmask;
  logic                 unused_addr_bits;

  lock_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 key_wr, lock_wr_other;
  logic [NUM_REGS-1:0]  prot_done, reg_err, w1c_bits;

  logic [DATA_W-1:0]    rd_nxt;
  logic                 rd_err, wr_err;
  logic [DATA_W-1:0]    rd_data_p1;
  logic                 vld_p1, err_p1;

  // A combined read+write cycle is a write only.
  assign wr               = chip_select & write_en;
  assign rd               = chip_select & read_en & ~write_en;
  assign waddr            = {addr[ADDR_W-1:2], 2'b00};
  assign in_range         = waddr < LOCK_ADDR;
  assign is_lock          = waddr == LOCK_ADDR;
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    bmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      bmask[8*b +: 8] = {8{wstrb[b]}};
    end
  end

  assign key_wr        = wr & is_lock & (&wstrb) & (write_data == KEY);
  assign lock_wr_other = wr & is_lock & ~key_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOCKED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the number of open cycles remaining, including the current one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOCKED: begin
        if (key_wr) begin
          state_nxt = OPEN;
          cnt_nxt   = CNT_LOAD;
        end
      end
      OPEN: begin
        if (key_wr) begin
          cnt_nxt = CNT_LOAD;
        end else if (lock_wr_other || (|prot_done) || cnt == CNT_W'(1)) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LOCKED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign unlocked = (state == OPEN);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [2:0]        ACC   = ACC_TYPE[3*i +: 3];
    localparam logic              IS_RO = (ACC > ACC_PULSE) || (ACC == ACC_RO);
    localparam logic [DATA_W-1:0] RV    = (ACC == ACC_PULSE) ? '0 : RST_VAL[i*DATA_W +: DATA_W];

    logic              sel, blocked, sw_ok;
    logic [DATA_W-1:0] q, q_nxt, hw_d;

    assign sel          = wr && (waddr == ADDR_W'(4 * i));
    assign blocked      = LOCK_MASK[i] && (state != OPEN);
    assign sw_ok        = sel & ~IS_RO & ~blocked;
    assign reg_err[i]   = sel & (IS_RO | blocked);
    assign prot_done[i] = sw_ok & LOCK_MASK[i];
    assign hw_d         = hw_wdata[i*DATA_W +: DATA_W];

    always_comb begin
      q_nxt = q;
      case (ACC)
        ACC_RW, ACC_WO: begin
          if (sw_ok)          q_nxt = (q & ~bmask) | (write_data & bmask);
          else if (hw_wen[i]) q_nxt = hw_d;
        end
        // A hardware set beats a software clear on the same bit.
        ACC_W1C: begin
          q_nxt = (q & ~(sw_ok ? (write_data & bmask) : '0)) | (hw_wen[i] ? hw_d : '0);
        end
        ACC_W1S: begin
          if (sw_ok)          q_nxt = q | (write_data & bmask);
          else if (hw_wen[i]) q_nxt = hw_d;
        end
        ACC_PULSE: begin
          if (sw_ok)          q_nxt = write_data & bmask;
          else if (hw_wen[i]) q_nxt = hw_d;
          else                q_nxt = '0;
        end
        default: begin
          if (hw_wen[i]) q_nxt = hw_d;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= RV;
      else        q <= q_nxt;
    end

    assign reg_q[i*DATA_W +: DATA_W] = q;
    assign w1c_bits[i]               = (ACC == ACC_W1C) && (|q);
  end

  assign irq = |w1c_bits;

  always_comb begin
    rd_nxt = '0;
    rd_err = 1'b0;
    if (is_lock) begin
      rd_nxt = {{(DATA_W-1){1'b0}}, unlocked};
    end else if (!in_range) begin
      rd_err = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (waddr == ADDR_W'(4 * i) && ACC_TYPE[3*i +: 3] != ACC_WO) begin
          rd_nxt = reg_q[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign wr_err = (wr & ~in_range & ~is_lock) | (|reg_err);

  // ---- stage p1: bus response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd;
      err_p1 <= (rd & rd_err) | wr_err;
      if (rd) rd_data_p1 <= rd_nxt;
    end
  end

  assign read_data  = rd_data_p1;
  assign data_valid = vld_p1;
  assign slv_err    = err_p1;

endmodule
